beat_controller: RTL and testbench
==================================

# beat_controller

Two-beat-cycle instruction controller for the lab CPU datapath, sitting directly downstream of the 4-phase beat counter. It consumes the one-hot beat vector T and, per instruction, runs one FETCH machine cycle (T1..T4) and one EXEC machine cycle (T1..T4). During these cycles it drives a 32-word asynchronous-read memory port and holds PC, IR, ACC and the Z/C flags. One instruction takes 8 clk; HLT parks the machine until reset.

## Interface
Parameters:
- PC_RESET, 5'd0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- T  in  4  beat vector from beat counter; T[0]=T1 … T[3]=T4; legal values are one-hot.
- mem_rdata  in  8  memory read data; valid combinationally in the same cycle mem_addr is driven.
- mem_addr  out  5  memory address, combinational from state/beat/PC/IR.
- mem_rd  out  1  read strobe, combinational.
- mem_wr  out  1  write strobe, combinational; memory writes on the clk edge ending the cycle.
- mem_wdata  out  8  always equals acc.
- pc  out  5  program counter (registered).
- ir  out  8  instruction register; [7:5] opcode, [4:0] address.
- acc  out  8  accumulator.
- z, c  out  1 each  zero flag / carry-borrow flag.
- halted  out  1  high in HALT state.

## Operation
- States: SYNC, FETCH, EXEC, HALT. Reset enters SYNC.
- Reset values: pc=PC_RESET, ir=0, acc=0, z=1, c=0, halted=0.
- A beat is valid only when T is one-hot. Non-one-hot T (including 0000) is a no-beat cycle:
  - no register changes,
  - mem_rd=mem_wr=0,
  - state held.
- SYNC: idle outputs. On T4 it goes to FETCH, so the first fetch starts aligned at T1.
- FETCH:
  - T1: mem_addr=pc, mem_rd=1.
  - T2: mem_addr=pc, mem_rd=1; ir<=mem_rdata; pc<=pc+1 (mod 32).
  - T3: idle.
  - T4: go to EXEC, or to HALT if ir[7:5]=HLT.
- EXEC opcodes (ir[7:5]), operand address A=ir[4:0]:
  - 000 NOP: nothing.
  - 001 LDA: T1 and T2 read A; at T2 latch operand into internal opnd. At T3: acc<=opnd, z updated, c unchanged.
  - 010 STA: T3 mem_addr=A, mem_wr=1, mem_wdata=acc.
  - 011 ADD: reads as LDA. At T3: {c,acc}<=acc+opnd (9-bit), z<=(result==0).
  - 100 SUB: reads as LDA. At T3: acc<=acc-opnd mod 256, c<=(acc<opnd) borrow, z updated.
  - 101 JMP: T3 pc<=A.
  - 110 JZ: T3 pc<=A if z=1, else pc unchanged.
  - 111 HLT: never reaches EXEC; it is diverted at FETCH T4.
- EXEC T4: go to FETCH.
- HALT: halted=1, all strobes 0, registers frozen, ignores T; left only by reset.
- mem_rd and mem_wr are never high together. Both are forced to 0 in any cycle with rst=0, regardless of state.
- mem_addr is 0 when neither strobe is active.

## Timing
- Beat counter is assumed to advance one phase per clk: T1→T2→T3→T4→T1.
- Latency from reset release to first fetch T1: 1–4 clk, depending on phase alignment.
- Instruction period: 8 clk in steady state (4 FETCH + 4 EXEC). HLT costs 4 clk, then stops.
- Register updates occur on the rising edge that ends the beat in which they are listed. Example: ir and pc are new from the cycle after FETCH T2; acc is new from EXEC T4.
- STA write occurs on the edge ending EXEC T3. A subsequent LDA of the same address reads the new value.
- Reset mid-instruction (any state, any beat):
  - strobes drop immediately (combinational gate),
  - all registers take reset values at the next edge,
  - any partial STA is suppressed.
- A no-beat cycle inserted mid-cycle stalls without losing position. The next valid beat resumes the action for that beat.
- PC wraps 31→0 on fetch increment. JMP/JZ targets are limited to 0–31.

## Test plan
- Program [0]=LDA 10, [1]=ADD 11, [2]=STA 12, [3]=HLT, with mem[10]=8'h7F, mem[11]=8'h01 → mem[12]=8'h80, acc=8'h80, c=0, z=0, halted=1 after 28 clk from first T1; pc=4.
- ADD overflow: acc=8'hFF (mem[10]=FF), ADD of mem[11]=01 → acc=00, c=1, z=1. Then JZ 5 → pc=5; with z=0, JZ 5 → pc unchanged.
- SUB borrow: acc=03, SUB mem=05 → acc=8'hFE, c=1, z=0.
- Reset released when T=T3 → state stays SYNC until T4, first mem_rd at next T1 with mem_addr=0. Reset asserted at EXEC T3 of STA → mem_wr=0 that cycle, target word unchanged, pc=0, acc=0.
- T forced to 4'b0000 for 3 clk between FETCH T1 and T2 → no register change during the stall. ir loaded on the following T2; result identical to the unstalled run.
- pc=31 fetching NOP → pc wraps to 0 and the next fetch reads address 0. mem_rd and mem_wr are never both 1 across all tests.

Source files
------------

// File: rtl/beat_controller_if.sv
// ---------------------------------------------------------------------------
// beat_controller_if
//
// Memory port between the beat controller and a 32 x 8 asynchronous-read
// memory.
//   mem_addr   word address, driven by the controller
//   mem_rd     read strobe; mem_rdata is valid in the same cycle
//   mem_wr     write strobe; memory captures mem_wdata on the edge ending
//              the cycle
//   mem_wdata  write data (the accumulator)
//   mem_rdata  read data returned by the memory
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface beat_controller_if;
    logic [4:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/beat_controller.sv
// ---------------------------------------------------------------------------
// beat_controller
//
// Two-machine-cycle instruction controller driven by a one-hot 4-phase beat
// vector. Each instruction runs a FETCH cycle (T1..T4) followed by an EXEC
// cycle (T1..T4); HLT is diverted to the HALT state at the end of FETCH and
// stays there until reset.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-low reset
//   T        beat vector, T[0]=T1 .. T[3]=T4; non-one-hot means "no beat"
//   mem      memory port (beat_controller_if.master)
//   pc       program counter
//   ir       instruction register, [7:5] opcode, [4:0] operand address
//   acc      accumulator
//   z, c     zero flag, carry/borrow flag
//   halted   high while in HALT
// ---------------------------------------------------------------------------
module beat_controller #(
    parameter logic [4:0] PC_RESET = 5'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               T,
    beat_controller_if.master        mem,
    output logic [4:0]               pc,
    output logic [7:0]               ir,
    output logic [7:0]               acc,
    output logic                     z,
    output logic                     c,
    output logic                     halted
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t     state_reg;
    logic [4:0] pc_reg;
    logic [7:0] ir_reg;
    logic [7:0] acc_reg;
    logic [7:0] opnd_reg;
    logic       z_reg;
    logic       c_reg;
    logic       halted_reg;

    // A beat is only honoured when exactly one bit of T is set; anything
    // else stalls the machine in place without losing its position.
    logic       beat_valid;
    logic [3:0] beat;

    assign beat_valid = (T != 4'b0000) && ((T & (T - 4'd1)) == 4'b0000);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_beat
            assign beat[gi] = beat_valid & T[gi];
        end
    endgenerate

    logic [2:0] opcode;
    logic [4:0] addr_a;
    logic       reads_opnd;
    logic [8:0] sum_next;
    logic [7:0] diff_next;

    assign opcode     = ir_reg[7:5];
    assign addr_a     = ir_reg[4:0];
    assign reads_opnd = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
    assign sum_next   = {1'b0, acc_reg} + {1'b0, opnd_reg};
    assign diff_next  = acc_reg - opnd_reg;

    // Memory strobes are combinational from state/beat and are gated by
    // rst so that a reset arriving mid-instruction cancels a pending write
    // in the very same cycle.
    logic       rd_strobe;
    logic       wr_strobe;
    logic [4:0] addr_drive;

    always_comb begin
        rd_strobe  = 1'b0;
        wr_strobe  = 1'b0;
        addr_drive = 5'd0;
        if (rst) begin
            case (state_reg)
                ST_FETCH: begin
                    if (beat[0] || beat[1]) begin
                        rd_strobe  = 1'b1;
                        addr_drive = pc_reg;
                    end
                end
                ST_EXEC: begin
                    if (reads_opnd && (beat[0] || beat[1])) begin
                        rd_strobe  = 1'b1;
                        addr_drive = addr_a;
                    end else if ((opcode == OP_STA) && beat[2]) begin
                        wr_strobe  = 1'b1;
                        addr_drive = addr_a;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.mem_addr  = addr_drive;
    assign mem.mem_rd    = rd_strobe;
    assign mem.mem_wr    = wr_strobe;
    assign mem.mem_wdata = acc_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_SYNC;
            pc_reg     <= PC_RESET;
            ir_reg     <= 8'h00;
            acc_reg    <= 8'h00;
            opnd_reg   <= 8'h00;
            z_reg      <= 1'b1;
            c_reg      <= 1'b0;
            halted_reg <= 1'b0;
        end else if (beat_valid) begin
            case (state_reg)
                ST_SYNC: begin
                    // Wait for T4 so the first fetch starts on T1.
                    if (beat[3]) begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (beat[1]) begin
                        ir_reg <= mem.mem_rdata;
                        pc_reg <= pc_reg + 5'd1;
                    end
                    if (beat[3]) begin
                        if (opcode == OP_HLT) begin
                            state_reg  <= ST_HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (beat[1] && reads_opnd) begin
                        opnd_reg <= mem.mem_rdata;
                    end
                    if (beat[2]) begin
                        case (opcode)
                            OP_LDA: begin
                                acc_reg <= opnd_reg;
                                z_reg   <= (opnd_reg == 8'h00);
                            end
                            OP_ADD: begin
                                acc_reg <= sum_next[7:0];
                                c_reg   <= sum_next[8];
                                z_reg   <= (sum_next[7:0] == 8'h00);
                            end
                            OP_SUB: begin
                                acc_reg <= diff_next;
                                c_reg   <= (acc_reg < opnd_reg);
                                z_reg   <= (diff_next == 8'h00);
                            end
                            OP_JMP: begin
                                pc_reg <= addr_a;
                            end
                            OP_JZ: begin
                                if (z_reg) begin
                                    pc_reg <= addr_a;
                                end
                            end
                            default: begin
                                // NOP, STA (write is purely combinational),
                                // HLT never gets here.
                            end
                        endcase
                    end
                    if (beat[3]) begin
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    // HALT: frozen until reset.
                end
            endcase
        end
    end

    assign pc     = pc_reg;
    assign ir     = ir_reg;
    assign acc    = acc_reg;
    assign z      = z_reg;
    assign c      = c_reg;
    assign halted = halted_reg;

endmodule

// File: tb/tb_beat_controller.sv
// ---------------------------------------------------------------------------
// tb_beat_controller
//
// Bench for beat_controller: models the 4-phase beat counter and a 32 x 8
// asynchronous-read memory, runs a table of small programs to HLT and
// compares results, then covers reset alignment, mid-STA reset, beat
// stalls and PC wrap with hand-written sequences.
// ---------------------------------------------------------------------------
module tb_beat_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] T;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [7:0] acc;
    logic       z;
    logic       c;
    logic       halted;

    always #5 clk = ~clk;

    beat_controller_if mif();

    beat_controller #(.PC_RESET(5'd0)) dut (
        .clk    (clk),
        .rst    (rst),
        .T      (T),
        .mem    (mif),
        .pc     (pc),
        .ir     (ir),
        .acc    (acc),
        .z      (z),
        .c      (c),
        .halted (halted)
    );

    logic [7:0] mem_arr [32];
    assign mif.mem_rdata = mem_arr[mif.mem_addr];

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    logic       s_rd;
    logic       s_wr;
    logic [4:0] s_addr;
    logic [7:0] s_wdata;

    typedef struct {
        logic [7:0] i0, i1, i2, i3;
        logic [7:0] d10, d11;
        logic [7:0] e_acc;
        logic       e_c, e_z;
        logic [4:0] e_pc;
        logic [7:0] e_m12;
        int         e_cyc;
        string      name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive T (or a no-beat), sample the memory port
    // mid-cycle, then apply any write on the edge ending the cycle.
    task automatic clk1(input bit nobeat);
        T = nobeat ? 4'b0000 : (4'b0001 << phase);
        #3;
        s_rd    = mif.mem_rd;
        s_wr    = mif.mem_wr;
        s_addr  = mif.mem_addr;
        s_wdata = mif.mem_wdata;
        chk("rd_wr_excl", int'(s_rd & s_wr), 0);
        if (!s_rd && !s_wr) chk("idle_addr", int'(s_addr), 0);
        @(posedge clk);
        #1;
        if (s_wr) mem_arr[s_addr] = s_wdata;
        if (!nobeat) phase = (phase + 1) % 4;
    endtask

    // Hold reset, then release so that the next driven beat is phase ph.
    task automatic release_at(input int ph);
        rst = 1'b0;
        clk1(1'b0);
        clk1(1'b0);
        while (phase != ph) clk1(1'b0);
        rst = 1'b1;
    endtask

    task automatic load_prog(input vec_t v);
        for (int i = 0; i < 32; i++) mem_arr[i] = 8'hE0;
        mem_arr[0]  = v.i0;
        mem_arr[1]  = v.i1;
        mem_arr[2]  = v.i2;
        mem_arr[3]  = v.i3;
        mem_arr[10] = v.d10;
        mem_arr[11] = v.d11;
    endtask

    // Runs until halted, counting cycles from the first fetch T1.
    task automatic run_to_halt(input int start_cnt, input bit already_seen, output int ncyc);
        bit seen;
        seen = already_seen;
        ncyc = start_cnt;
        for (int k = 0; k < 300; k++) begin
            clk1(1'b0);
            if (s_rd) seen = 1'b1;
            if (seen) ncyc++;
            if (halted) break;
        end
    endtask

    initial begin
        int ncyc;
        int found;

        //            i0     i1     i2     i3     d10    d11    acc    c     z     pc    m12    cyc name
        vecs[0] = '{8'h2A, 8'h6B, 8'h4C, 8'hE0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 5'd4, 8'h80, 28, "lda_add_sta"};
        vecs[1] = '{8'h2A, 8'h6B, 8'hC5, 8'hE0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 5'd6, 8'hE0, 28, "add_ovf_jz_taken"};
        vecs[2] = '{8'h2A, 8'h6B, 8'hC5, 8'hE0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 5'd4, 8'hE0, 28, "jz_not_taken"};
        vecs[3] = '{8'h2A, 8'h8B, 8'h4C, 8'hE0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 5'd4, 8'hFE, 28, "sub_borrow"};
        vecs[4] = '{8'h2A, 8'h6B, 8'h2C, 8'hE0, 8'hFF, 8'h01, 8'hE0, 1'b1, 1'b0, 5'd4, 8'hE0, 28, "lda_keeps_c"};
        vecs[5] = '{8'h2A, 8'h8B, 8'h4C, 8'hE0, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 5'd4, 8'h00, 28, "sub_equal"};
        vecs[6] = '{8'hA6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 5'd7, 8'hE0, 12, "jmp"};
        vecs[7] = '{8'h2A, 8'h4C, 8'h6C, 8'hE0, 8'h42, 8'h00, 8'h84, 1'b0, 1'b0, 5'd4, 8'h42, 28, "sta_then_add"};
        vecs[8] = '{8'h2A, 8'h8B, 8'h4C, 8'hE0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 5'd4, 8'h02, 28, "sub_no_borrow"};

        rst = 1'b0;
        T   = 4'b0000;
        for (int i = 0; i < 32; i++) mem_arr[i] = 8'hE0;
        @(posedge clk);
        #1;

        // ---- table-driven programs ----
        for (int v = 0; v < 9; v++) begin
            load_prog(vecs[v]);
            release_at(v % 4);
            run_to_halt(0, 1'b0, ncyc);
            chk({vecs[v].name, "_halted"}, int'(halted), 1);
            chk({vecs[v].name, "_acc"},    int'(acc), int'(vecs[v].e_acc));
            chk({vecs[v].name, "_c"},      int'(c),   int'(vecs[v].e_c));
            chk({vecs[v].name, "_z"},      int'(z),   int'(vecs[v].e_z));
            chk({vecs[v].name, "_pc"},     int'(pc),  int'(vecs[v].e_pc));
            chk({vecs[v].name, "_m12"},    int'(mem_arr[12]), int'(vecs[v].e_m12));
            chk({vecs[v].name, "_cycles"}, ncyc, vecs[v].e_cyc);
            // HALT ignores beats and keeps everything frozen.
            for (int k = 0; k < 6; k++) begin
                clk1(1'b0);
                chk({vecs[v].name, "_halt_rd"}, int'(s_rd), 0);
            end
            chk({vecs[v].name, "_halt_pc"}, int'(pc), int'(vecs[v].e_pc));
            $display("VEC %0d %s acc=%02h c=%0d z=%0d pc=%0d m12=%02h cyc=%0d",
                     v, vecs[v].name, acc, c, z, pc, mem_arr[12], ncyc);
        end

        // ---- reset from the halted state restores reset values ----
        rst = 1'b0;
        clk1(1'b0);
        chk("rst_rd", int'(s_rd), 0);
        clk1(1'b0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_ir", int'(ir), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_z", int'(z), 1);
        chk("rst_c", int'(c), 0);
        chk("rst_halted", int'(halted), 0);
        $display("SEQ reset_values pc=%0d acc=%02h z=%0d halted=%0d", pc, acc, z, halted);

        // ---- release on T3: SYNC waits for T4, first fetch on T1 ----
        load_prog(vecs[0]);
        release_at(2);
        clk1(1'b0);
        chk("t3rel_t3_rd", int'(s_rd), 0);
        clk1(1'b0);
        chk("t3rel_t4_rd", int'(s_rd), 0);
        clk1(1'b0);
        chk("t3rel_t1_rd", int'(s_rd), 1);
        chk("t3rel_t1_addr", int'(s_addr), 0);
        $display("SEQ release_t3 first_rd=%0d addr=%0d", s_rd, s_addr);

        // ---- reset asserted during EXEC T3 of STA ----
        load_prog(vecs[0]);
        release_at(3);
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            T = 4'b0001 << phase;
            #2;
            if (mif.mem_wr) begin
                found = 1;
                chk("sta_addr", int'(mif.mem_addr), 12);
                rst = 1'b0;
                #1;
                chk("rst_gate_wr", int'(mif.mem_wr), 0);
                chk("rst_gate_rd", int'(mif.mem_rd), 0);
            end else begin
                #1;
            end
            s_wr    = mif.mem_wr;
            s_addr  = mif.mem_addr;
            s_wdata = mif.mem_wdata;
            @(posedge clk);
            #1;
            if (s_wr) mem_arr[s_addr] = s_wdata;
            phase = (phase + 1) % 4;
        end
        chk("sta_reached", found, 1);
        chk("midrst_pc", int'(pc), 0);
        chk("midrst_acc", int'(acc), 0);
        chk("midrst_ir", int'(ir), 0);
        chk("midrst_m12", int'(mem_arr[12]), 8'hE0);
        $display("SEQ reset_mid_sta pc=%0d acc=%02h m12=%02h", pc, acc, mem_arr[12]);

        // ---- 3 no-beat cycles between FETCH T1 and T2 ----
        load_prog(vecs[0]);
        release_at(1);
        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            clk1(1'b0);
            if (s_rd) found = 1;
        end
        chk("stall_first_t1", found, 1);
        for (int k = 0; k < 3; k++) begin
            clk1(1'b1);
            chk("stall_rd", int'(s_rd), 0);
            chk("stall_ir", int'(ir), 0);
            chk("stall_pc", int'(pc), 0);
        end
        clk1(1'b0);
        chk("stall_t2_rd", int'(s_rd), 1);
        chk("stall_t2_ir", int'(ir), 8'h2A);
        chk("stall_t2_pc", int'(pc), 1);
        run_to_halt(5, 1'b1, ncyc);
        chk("stall_halted", int'(halted), 1);
        chk("stall_acc", int'(acc), 8'h80);
        chk("stall_m12", int'(mem_arr[12]), 8'h80);
        chk("stall_pc_end", int'(pc), 4);
        chk("stall_cycles", ncyc, 31);
        $display("SEQ stall acc=%02h m12=%02h pc=%0d cyc=%0d", acc, mem_arr[12], pc, ncyc);

        // ---- PC wrap: JMP 31, NOP at 31, next fetch from 0 ----
        for (int i = 0; i < 32; i++) mem_arr[i] = 8'hE0;
        mem_arr[0]  = 8'hBF;
        mem_arr[31] = 8'h00;
        release_at(3);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            clk1(1'b0);
            if (s_rd && s_addr == 5'd31) found = 1;
        end
        chk("wrap_fetch31", found, 1);
        clk1(1'b0);
        chk("wrap_pc", int'(pc), 0);
        chk("wrap_ir", int'(ir), 8'h00);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            clk1(1'b0);
            if (s_rd) found = 1;
        end
        chk("wrap_next_fetch", found, 1);
        chk("wrap_next_addr", int'(s_addr), 0);
        $display("SEQ pc_wrap pc=%0d next_addr=%0d", pc, s_addr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
